// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the fetch-buffer entry type.
package mips_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {instr, pc} fetch entries with flush; head is presented
// combinationally and reads as an all-zero entry while empty.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);
    localparam fetch_entry_t EMPTY_ENTRY = '{instr: NOP, pc: '0};

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only ever observed after a push wrote it.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? EMPTY_ENTRY : mem[rd_ptr];
endmodule

// File: rtl/ifetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues pipelined imem reads under a credit limit,
// and buffers returned words for decode. Defining IFETCH_PERF_CNT_EN adds fetch/stall counters.
module ifetch_stage
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]        o_IF_fetchCnt,
    output logic [31:0]        o_IF_stallCnt,
`endif
    input  logic               i_IF_pause,
    input  logic               i_IF_redirect,
    input  logic [ADDR_W-1:0]  i_IF_redirectPc,
    output logic               o_IF_imemReq,
    output logic [ADDR_W-1:0]  o_IF_imemAddr,
    input  logic               i_IF_imemGnt,
    input  logic               i_IF_imemRvalid,
    input  logic [INSTR_W-1:0] i_IF_imemRdata,
    output logic               o_IF_valid,
    output logic [INSTR_W-1:0] o_IF_instr,
    output logic [ADDR_W-1:0]  o_IF_pc,
    output logic [ADDR_W-1:0]  o_IF_pcPlus4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_next;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     fifo_count;
    logic [ADDR_W-1:0] inflight_pc [FIFO_DEPTH];
    logic [IW-1:0]     inflight_wr;
    logic [IW-1:0]     inflight_rd;
    logic              issue;
    logic              keep_word;
    logic              pop;
    logic              fifo_empty;
    fetch_entry_t      head;

    // Reads in flight plus buffered words never exceed the buffer depth, so a return always fits.
    assign o_IF_imemReq  = !rst && !i_IF_redirect &&
                           (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_V);
    assign o_IF_imemAddr = pc;

    assign issue     = o_IF_imemReq && i_IF_imemGnt;
    assign keep_word = i_IF_imemRvalid && (drop == '0) && !i_IF_redirect;
    assign pop       = !fifo_empty && !i_IF_pause && !i_IF_redirect;
    assign outstanding_next = outstanding + CW'(issue) - CW'(i_IF_imemRvalid);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            inflight_wr <= '0;
            inflight_rd <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (issue)           inflight_wr <= inflight_wr + 1'b1;
            if (i_IF_imemRvalid) inflight_rd <= inflight_rd + 1'b1;
            if (i_IF_redirect) begin
                // Every read still outstanding after this cycle belongs to the old path.
                pc   <= word_align(i_IF_redirectPc);
                drop <= outstanding_next;
            end else begin
                if (issue) pc <= pc + 32'd4;
                if (i_IF_imemRvalid && (drop != '0)) drop <= drop - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) inflight_pc[inflight_wr] <= pc;
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (i_IF_redirect),
        .push      (keep_word),
        .push_data ('{instr: i_IF_imemRdata, pc: inflight_pc[inflight_rd]}),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_IF_valid   = !fifo_empty;
    assign o_IF_instr   = head.instr;
    assign o_IF_pc      = head.pc;
    assign o_IF_pcPlus4 = head.pc + 32'd4;

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_IF_fetchCnt <= '0;
            o_IF_stallCnt <= '0;
        end else begin
            if (pop)                      o_IF_fetchCnt <= o_IF_fetchCnt + 32'd1;
            if (i_IF_pause && o_IF_valid) o_IF_stallCnt <= o_IF_stallCnt + 32'd1;
        end
    end
`endif

    underflow_a: assert property (@(posedge clk) disable iff (rst)
        i_IF_imemRvalid |-> (outstanding != '0));
endmodule

// File: tb/tb_ifetch_stage.sv
// Scoreboard bench for ifetch_stage: an imem responder feeds returns, expected {instr,pc}
// entries are queued on return and a monitor compares every word decode consumes.
module tb_ifetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] addr;
        logic        stale;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pause = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    // Values applied to the DUT at the next falling edge.
    logic        n_rst = 1'b1;
    logic        n_pause = 1'b0;
    logic        n_redirect = 1'b0;
    logic [31:0] n_redirect_pc = '0;
    logic        n_gnt = 1'b0;
    logic        resp_en = 1'b1;
    logic        sched_on = 1'b0;
    int          pops_left = 0;
    int          stalls_left = 0;

    resp_t       resp_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] hs_log[$];
    logic [31:0] model_pc = RESET_PC;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    ifetch_stage dut (
        .clk             (clk),
        .rst             (rst),
`ifdef IFETCH_PERF_CNT_EN
        .o_IF_fetchCnt   (fetch_cnt),
        .o_IF_stallCnt   (stall_cnt),
`endif
        .i_IF_pause      (pause),
        .i_IF_redirect   (redirect),
        .i_IF_redirectPc (redirect_pc),
        .o_IF_imemReq    (imem_req),
        .o_IF_imemAddr   (imem_addr),
        .i_IF_imemGnt    (gnt),
        .i_IF_imemRvalid (rvalid),
        .i_IF_imemRdata  (rdata),
        .o_IF_valid      (if_valid),
        .o_IF_instr      (if_instr),
        .o_IF_pc         (if_pc),
        .o_IF_pcPlus4    (if_pc_plus4)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_log(input string name, input logic [31:0] log_q[$], input int idx,
                             input logic [31:0] exp);
        if (idx >= log_q.size()) begin
            total++;
            bad++;
            $display("FAIL %s: entry %0d missing (only %0d recorded), expected %h",
                     name, idx, log_q.size(), exp);
        end else begin
            check(name, log_q[idx], exp);
        end
    endtask

    // One clock: apply inputs at the falling edge, play the imem responder, log the handshake.
    task automatic tick();
        resp_t r;
        @(negedge clk);
        rst         = n_rst;
        pause       = n_pause;
        redirect    = n_redirect;
        redirect_pc = n_redirect_pc;
        gnt         = n_gnt;
        if (sched_on) begin
            if (if_valid) begin
                if (stalls_left > 0) begin
                    pause = 1'b1;
                    stalls_left--;
                end else if (pops_left > 0) begin
                    pause = 1'b0;
                    pops_left--;
                end else begin
                    pause = 1'b1;
                end
            end else begin
                pause = 1'b0;
            end
        end
        rvalid = 1'b0;
        rdata  = '0;
        if (rst) begin
            resp_q.delete();
            exp_q.delete();
            pop_log.delete();
            hs_log.delete();
            model_pc = RESET_PC;
        end else begin
            if (resp_en && resp_q.size() != 0) begin
                r      = resp_q.pop_front();
                rvalid = 1'b1;
                rdata  = mem_word(r.addr);
                if (!r.stale && !redirect) exp_q.push_back(r.addr);
            end
            if (redirect) begin
                exp_q.delete();
                foreach (resp_q[i]) resp_q[i].stale = 1'b1;
                model_pc = {redirect_pc[31:2], 2'b00};
            end
        end
        #1;
        if (!rst && imem_req && gnt) begin
            check("hs_addr", imem_addr, model_pc);
            hs_log.push_back(imem_addr);
            resp_q.push_back('{addr: imem_addr, stale: 1'b0});
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b1;
        tick();
        tick();
        n_rst = 1'b0;
    endtask

    task automatic drain(input string name);
        n_gnt      = 1'b0;
        n_pause    = 1'b0;
        n_redirect = 1'b0;
        resp_en    = 1'b1;
        for (int i = 0; i < 30 && (exp_q.size() != 0 || resp_q.size() != 0); i++) begin
            tick();
            #2;
        end
        check(name, 32'(exp_q.size() + resp_q.size()), 32'd0);
    endtask

    // Monitor: every word decode consumes must be the next expected one.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !redirect && !pause && if_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got pc %h with nothing expected", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", if_pc, e);
                    check("pop_instr", if_instr, mem_word(e));
                    check("pop_pc_plus4", if_pc_plus4, e + 32'd4);
                end
                pop_log.push_back(if_pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, first fetches and latency.
        do_reset();
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_pc_plus4", if_pc_plus4, 32'd4);
        n_gnt = 1'b1; resp_en = 1'b1; n_pause = 1'b0;
        tick();
        check("t1_c0_req", 32'(imem_req), 32'd1);
        check("t1_c0_addr", imem_addr, 32'h0000_3000);
        check("t1_c0_valid", 32'(if_valid), 32'd0);
        tick();
        check("t1_c1_valid", 32'(if_valid), 32'd0);
        check("t1_c1_addr", imem_addr, 32'h0000_3004);
        tick();
        check("t1_c2_valid", 32'(if_valid), 32'd1);
        check("t1_c2_pc", if_pc, 32'h0000_3000);
        repeat (6) tick();
        #2;
        check_log("t1_hs0", hs_log, 0, 32'h0000_3000);
        check_log("t1_hs1", hs_log, 1, 32'h0000_3004);
        check_log("t1_hs2", hs_log, 2, 32'h0000_3008);
        check_log("t1_pop0", pop_log, 0, 32'h0000_3000);
        check_log("t1_pop1", pop_log, 1, 32'h0000_3004);
        check_log("t1_pop2", pop_log, 2, 32'h0000_3008);
        drain("t1_drain");

        // Pause with a full buffer: head holds, no new request, nothing lost.
        do_reset();
        n_gnt = 1'b1; n_pause = 1'b1;
        repeat (3) tick();
        for (int k = 3; k < 6; k++) begin
            tick();
            check("t2_valid", 32'(if_valid), 32'd1);
            check("t2_pc", if_pc, 32'h0000_3000);
            check("t2_instr", if_instr, mem_word(32'h0000_3000));
            check("t2_req", 32'(imem_req), 32'd0);
        end
        n_pause = 1'b0;
        repeat (7) tick();
        #2;
        check_log("t2_pop0", pop_log, 0, 32'h0000_3000);
        check_log("t2_pop1", pop_log, 1, 32'h0000_3004);
        check_log("t2_pop2", pop_log, 2, 32'h0000_3008);
        drain("t2_drain");

        // Redirect with two reads in flight: both returns dropped, fetch from aligned target.
        do_reset();
        n_gnt = 1'b1; resp_en = 1'b0;
        tick();
        tick();
        n_redirect = 1'b1; n_redirect_pc = 32'h0000_4002;
        tick();
        check("t3_redirect_req", 32'(imem_req), 32'd0);
        n_redirect = 1'b0; resp_en = 1'b1;
        tick();
        check("t3_c3_valid", 32'(if_valid), 32'd0);
        repeat (6) tick();
        #2;
        check_log("t3_hs2", hs_log, 2, 32'h0000_4000);
        check_log("t3_pop0", pop_log, 0, 32'h0000_4000);
        check_log("t3_pop1", pop_log, 1, 32'h0000_4004);
        drain("t3_drain");

        // Redirect and pause together: buffer flushed, fetch from target.
        do_reset();
        n_gnt = 1'b1; n_pause = 1'b1;
        repeat (4) tick();
        check("t4_full_valid", 32'(if_valid), 32'd1);
        n_redirect = 1'b1; n_redirect_pc = 32'h0000_5000;
        tick();
        n_redirect = 1'b0; n_pause = 1'b0;
        tick();
        check("t4_flushed_valid", 32'(if_valid), 32'd0);
        check("t4_req", 32'(imem_req), 32'd1);
        check("t4_addr", imem_addr, 32'h0000_5000);
        repeat (5) tick();
        #2;
        check_log("t4_pop0", pop_log, 0, 32'h0000_5000);
        drain("t4_drain");

        // Grant withheld: request and address hold; PC wraps past the top of memory.
        do_reset();
        n_gnt = 1'b0; n_redirect = 1'b1; n_redirect_pc = 32'hFFFF_FFFC;
        tick();
        n_redirect = 1'b0;
        for (int k = 1; k < 5; k++) begin
            tick();
            check("t5_hold_req", 32'(imem_req), 32'd1);
            check("t5_hold_addr", imem_addr, 32'hFFFF_FFFC);
        end
        n_gnt = 1'b1;
        tick();
        tick();
        check("t5_wrap_addr", imem_addr, 32'h0000_0000);
        repeat (5) tick();
        #2;
        check_log("t5_pop0", pop_log, 0, 32'hFFFF_FFFC);
        check_log("t5_pop1", pop_log, 1, 32'h0000_0000);
        drain("t5_drain");

`ifdef IFETCH_PERF_CNT_EN
        // Counters: three stall cycles then ten pops; mid-run reset clears both.
        do_reset();
        n_gnt = 1'b1; n_pause = 1'b0;
        stalls_left = 3; pops_left = 10; sched_on = 1'b1;
        for (int i = 0; i < 200 && (pops_left > 0 || stalls_left > 0); i++) tick();
        sched_on = 1'b0;
        check("t6_budget_left", 32'(pops_left + stalls_left), 32'd0);
        n_pause = 1'b0;
        tick();
        check("t6_fetch_cnt", fetch_cnt, 32'd10);
        check("t6_stall_cnt", stall_cnt, 32'd3);
        do_reset();
        check("t6_rst_fetch_cnt", fetch_cnt, 32'd0);
        check("t6_rst_stall_cnt", stall_cnt, 32'd0);
        n_gnt = 1'b1;
        repeat (4) tick();
        #2;
        check_log("t6_restart_pop0", pop_log, 0, 32'h0000_3000);
        drain("t6_drain");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
